// File: rtl/serial_packet_tx.sv
// Serial frame transmitter: shifts out start bit, port, length and N payload bits
// on a single wire, one bit per clkEn tick.
module serial_packet_tx #(
  parameter int unsigned PORT_W = 2,
  parameter int unsigned LEN_W  = 4,
  parameter int unsigned DATA_W = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clkEn,
  input  logic              start,
  input  logic [PORT_W-1:0] portIn,
  input  logic [LEN_W-1:0]  lenIn,
  input  logic [DATA_W-1:0] dataIn,
  output logic              serOut,
  output logic              dataValid,
  output logic              busy,
  output logic              ready,
  output logic              done
);

  localparam int unsigned MAX_W   = (PORT_W > LEN_W) ? ((PORT_W > DATA_W) ? PORT_W : DATA_W)
                                                     : ((LEN_W > DATA_W) ? LEN_W : DATA_W);
  localparam int unsigned CNT_MAX = MAX_W - 1;
  localparam int unsigned CNT_W   = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;

  typedef enum logic [2:0] {IDLE, START, PORT, LEN, DATA} state_t;

  state_t              state, state_d;
  logic [PORT_W-1:0]   port_q, port_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    n_q, n_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [CNT_W-1:0]    cnt, cnt_d;
  logic                ser_d, dv_d, busy_d, ready_d, done_d;
  logic [LEN_W-1:0]    len_clamp_c;
  logic [DATA_W-1:0]   data_align_c;

  // Payload is pre-aligned so bit N-1 sits at the MSB and shifts out first
  assign len_clamp_c  = (32'(lenIn) > DATA_W) ? LEN_W'(DATA_W) : lenIn;
  assign data_align_c = dataIn << (DATA_W - 32'(len_clamp_c));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      port_q    <= '0;
      len_q     <= '0;
      n_q       <= '0;
      data_q    <= '0;
      cnt       <= '0;
      serOut    <= 1'b1;
      dataValid <= 1'b0;
      busy      <= 1'b0;
      ready     <= 1'b1;
      done      <= 1'b0;
    end else if (clkEn) begin
      state     <= state_d;
      port_q    <= port_d;
      len_q     <= len_d;
      n_q       <= n_d;
      data_q    <= data_d;
      cnt       <= cnt_d;
      serOut    <= ser_d;
      dataValid <= dv_d;
      busy      <= busy_d;
      ready     <= ready_d;
      done      <= done_d;
    end else begin
      // done is a single-clk pulse even when the strobe is sparse
      done      <= 1'b0;
    end
  end

  always_comb begin
    state_d = state;
    port_d  = port_q;
    len_d   = len_q;
    n_d     = n_q;
    data_d  = data_q;
    cnt_d   = cnt;
    ser_d   = serOut;
    dv_d    = dataValid;
    busy_d  = busy;
    ready_d = ready;
    done_d  = 1'b0;

    unique case (state)
      IDLE: begin
        ser_d = 1'b1;
        if (start) begin
          port_d  = portIn;
          len_d   = len_clamp_c;
          n_d     = len_clamp_c;
          data_d  = data_align_c;
          ser_d   = 1'b0;
          busy_d  = 1'b1;
          ready_d = 1'b0;
          state_d = START;
        end
      end
      START: begin
        ser_d   = port_q[PORT_W-1];
        port_d  = port_q << 1;
        cnt_d   = CNT_W'(PORT_W - 1);
        state_d = PORT;
      end
      PORT: begin
        if (cnt == '0) begin
          ser_d   = len_q[LEN_W-1];
          len_d   = len_q << 1;
          cnt_d   = CNT_W'(LEN_W - 1);
          state_d = LEN;
        end else begin
          ser_d  = port_q[PORT_W-1];
          port_d = port_q << 1;
          cnt_d  = cnt - CNT_W'(1);
        end
      end
      LEN: begin
        if (cnt != '0) begin
          ser_d = len_q[LEN_W-1];
          len_d = len_q << 1;
          cnt_d = cnt - CNT_W'(1);
        end else if (n_q != '0) begin
          ser_d   = data_q[DATA_W-1];
          data_d  = data_q << 1;
          dv_d    = 1'b1;
          cnt_d   = CNT_W'(n_q) - CNT_W'(1);
          state_d = DATA;
        end else begin
          ser_d   = 1'b1;
          dv_d    = 1'b0;
          busy_d  = 1'b0;
          ready_d = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      DATA: begin
        if (cnt != '0) begin
          ser_d  = data_q[DATA_W-1];
          data_d = data_q << 1;
          cnt_d  = cnt - CNT_W'(1);
        end else begin
          ser_d   = 1'b1;
          dv_d    = 1'b0;
          busy_d  = 1'b0;
          ready_d = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_serial_packet_tx.sv
// Bench for serial_packet_tx: a frame-level model fills an expectation queue on
// accept; an independent monitor pops and compares on every output tick.
module tb_serial_packet_tx;

  localparam int unsigned PORT_W = 2;
  localparam int unsigned LEN_W  = 4;
  localparam int unsigned DATA_W = 15;

  typedef struct packed {
    logic ser;
    logic dv;
    logic last;
  } exp_t;

  logic              clk, rst, clkEn, start;
  logic [PORT_W-1:0] portIn;
  logic [LEN_W-1:0]  lenIn;
  logic [DATA_W-1:0] dataIn;
  logic              serOut, dataValid, busy, ready, done;

  int   checks = 0;
  int   errors = 0;
  int   accepted = 0;
  int   remaining = 0;
  int   en_mode = 0;
  int   phase = 0;
  exp_t exp_q[$];

  serial_packet_tx #(.PORT_W(PORT_W), .LEN_W(LEN_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .clkEn(clkEn), .start(start),
    .portIn(portIn), .lenIn(lenIn), .dataIn(dataIn),
    .serOut(serOut), .dataValid(dataValid), .busy(busy), .ready(ready), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic s, input logic v, input logic l);
    exp_t e;
    e.ser = s; e.dv = v; e.last = l;
    return e;
  endfunction

  // Reference frame: 0, port MSB-first, len MSB-first, data[N-1..0], then idle/done tick
  function automatic void push_frame(input logic [PORT_W-1:0] p, input logic [LEN_W-1:0] l,
                                     input logic [DATA_W-1:0] d);
    int n;
    n = (int'(l) > DATA_W) ? DATA_W : int'(l);
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0));
    for (int i = PORT_W - 1; i >= 0; i--) exp_q.push_back(mk(p[i], 1'b0, 1'b0));
    for (int i = LEN_W - 1; i >= 0; i--) exp_q.push_back(mk(l[i], 1'b0, 1'b0));
    for (int i = n - 1; i >= 0; i--) exp_q.push_back(mk(d[i], 1'b1, 1'b0));
    exp_q.push_back(mk(1'b1, 1'b0, 1'b1));
  endfunction

  // Model: busy for 1+PORT_W+LEN_W+N enabled ticks after accept, then free
  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
      remaining = 0;
    end else if (clkEn) begin
      if (remaining > 0) begin
        remaining--;
      end else if (start) begin
        push_frame(portIn, lenIn, dataIn);
        remaining = 1 + PORT_W + LEN_W + ((int'(lenIn) > DATA_W) ? DATA_W : int'(lenIn));
        accepted++;
      end
    end
  end

  // Monitor
  logic prev_ser = 1'b1, prev_dv = 1'b0, prev_busy = 1'b0;
  always @(posedge clk) begin
    logic en_s, rst_s;
    exp_t e;
    en_s  = clkEn;
    rst_s = rst;
    #1;
    if (!rst_s) begin
      if (en_s) begin
        if (busy || done) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_output", {30'd0, busy, done}, 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("serOut", 32'(serOut), 32'(e.ser));
            chk("dataValid", 32'(dataValid), 32'(e.dv));
            chk("done", 32'(done), 32'(e.last));
            chk("busy", 32'(busy), 32'(!e.last));
          end
        end else begin
          chk("idle_serOut", 32'(serOut), 32'd1);
          chk("idle_dataValid", 32'(dataValid), 32'd0);
        end
      end else begin
        chk("done_one_clk", 32'(done), 32'd0);
        chk("hold_serOut", 32'(serOut), 32'(prev_ser));
        chk("hold_dataValid", 32'(dataValid), 32'(prev_dv));
        chk("hold_busy", 32'(busy), 32'(prev_busy));
      end
    end
    chk("ready_vs_busy", 32'(ready), 32'(!busy));
    prev_ser  = serOut;
    prev_dv   = dataValid;
    prev_busy = busy;
  end

  // Strobe generator: 0 = always on, 1 = one in three, 2 = random
  always @(negedge clk) begin
    case (en_mode)
      0: clkEn = 1'b1;
      1: begin
        clkEn = (phase == 0);
        phase = (phase == 2) ? 0 : phase + 1;
      end
      default: clkEn = ($urandom_range(0, 3) != 0);
    endcase
  end

  task automatic wait_accept();
    int prev;
    bit got;
    prev = accepted;
    got  = 1'b0;
    for (int i = 0; i < 1000 && !got; i++) begin
      @(negedge clk);
      if (accepted != prev) got = 1'b1;
    end
    if (!got) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    bit got;
    got = 1'b0;
    for (int i = 0; i < 2000 && !got; i++) begin
      @(negedge clk);
      if (remaining == 0 && exp_q.size() == 0) got = 1'b1;
    end
    if (!got) chk("idle_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic send(input logic [PORT_W-1:0] p, input logic [LEN_W-1:0] l,
                      input logic [DATA_W-1:0] d);
    @(negedge clk);
    portIn = p; lenIn = l; dataIn = d; start = 1'b1;
    wait_accept();
    start = 1'b0;
    portIn = PORT_W'($urandom); lenIn = LEN_W'($urandom); dataIn = DATA_W'($urandom);
    wait_idle();
  endtask

  // Second request held on start with new fields while the first frame runs
  task automatic send_held(input logic [PORT_W-1:0] p, input logic [LEN_W-1:0] l,
                           input logic [DATA_W-1:0] d);
    @(negedge clk);
    portIn = p; lenIn = l; dataIn = d; start = 1'b1;
    wait_accept();
    portIn = PORT_W'($urandom); lenIn = LEN_W'($urandom); dataIn = DATA_W'($urandom);
    wait_accept();
    start = 1'b0;
    wait_idle();
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_serOut"}, 32'(serOut), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_dataValid"}, 32'(dataValid), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_ready"}, 32'(ready), 32'd1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; clkEn = 1'b1;
    portIn = '0; lenIn = '0; dataIn = '0;
    repeat (3) @(posedge clk);
    #2 check_reset_state("reset");
    @(negedge clk);
    rst = 1'b0;

    en_mode = 0;
    send(2'b10, 4'd3, 15'h0005);
    send(2'b01, 4'd0, 15'h7fff);
    send(2'b11, 4'd15, 15'h5555);
    en_mode = 1;
    send(2'b10, 4'd3, 15'h0005);
    en_mode = 0;
    send_held(2'b10, 4'd3, 15'h0005);

    // Reset while the length field is on the line
    @(negedge clk);
    portIn = 2'b10; lenIn = 4'd3; dataIn = 15'h0005; start = 1'b1;
    wait_accept();
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #2 check_reset_state("mid_reset");
    @(negedge clk);
    rst = 1'b0;
    send(2'b10, 4'd3, 15'h0005);

    for (int k = 0; k < 30; k++) begin
      en_mode = $urandom_range(0, 2);
      if ($urandom_range(0, 3) == 0)
        send_held(PORT_W'($urandom), LEN_W'($urandom_range(0, 15)), DATA_W'($urandom));
      else
        send(PORT_W'($urandom), LEN_W'($urandom_range(0, 15)), DATA_W'($urandom));
    end

    en_mode = 0;
    repeat (5) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
